cla_pipe_addsub: RTL

//  Parametrised, pipelined carry-lookahead adder/subtractor. WIDTH-bit operands are split into
//  BLK-bit lookahead groups; GPS groups are evaluated per pipeline stage, with the inter-stage carry
//  and the pending operand slices registered. Valid/ready handshake with full backpressure.

---
 rtl/cla_pkg.sv | 18 +
 rtl/cla_group.sv | 47 ++++
 rtl/cla_pipe_addsub.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared helpers for the pipelined carry-lookahead adder/subtractor
//
// Purpose: stage-count helper and the group propagate/generate record shared by
//          cla_group and cla_pipe_addsub.
package cla_pkg;

    // Group-level lookahead terms: p = whole group propagates, g = group generates.
    typedef struct packed {
        logic p;
        logic g;
    } grp_pg_t;

    // Number of pipeline stages for a given operand width and stage slice width.
    function automatic int cla_nstg(input int width, input int blk, input int gps);
        return width / (blk * gps);
    endfunction

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - combinational BLK-bit carry-lookahead group
//
// Purpose: one lookahead group. Bit carries inside the group are resolved from
//          per-bit generate/propagate; the group also exports its own P/G so the
//          caller can chain groups with lookahead instead of a rippled carry.
// Ports:
//   x, y  in  BLK  operand slices (y already inverted for subtract)
//   ci    in  1    carry into bit 0 of the group
//   s     out BLK  sum slice
//   pg    out 2    group propagate / generate
module cla_group
    import cla_pkg::*;
#(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] x,
    input  logic [BLK-1:0] y,
    input  logic           ci,
    output logic [BLK-1:0] s,
    output grp_pg_t        pg
);

    logic [BLK-1:0] p;
    logic [BLK-1:0] g;
    logic [BLK-1:0] c;
    logic           g_acc;

    always_comb begin
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = ci;
        for (int i = 1; i < BLK; i++) begin
            c[i] = g[i-1] | (p[i-1] & c[i-1]);
        end
        s = p ^ c;

        // Group generate: carry out of the group assuming a zero carry in.
        g_acc = 1'b0;
        for (int i = 0; i < BLK; i++) begin
            g_acc = g[i] | (p[i] & g_acc);
        end
        pg.p = &p;
        pg.g = g_acc;
    end

endmodule

// File: rtl/cla_pipe_addsub.sv
// rtl/cla_pipe_addsub.sv - pipelined carry-lookahead adder/subtractor with valid/ready
//
// Purpose: WIDTH-bit add/sub split into NSTG = WIDTH/(BLK*GPS) pipeline stages.
//          Stage k resolves bits [k*SW +: SW] with GPS chained lookahead groups,
//          using the carry registered by stage k-1. The result bits already
//          produced and the operand bits not yet consumed travel with the beat.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       operand handshake (in_ready = pipeline may advance)
//   X, Y, Ci, sub           operands, carry-in, subtract select (Y inverted)
//   out_valid/out_ready     result handshake
//   S, Co, ovf, zero        result and flags, all registered in the last stage
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLK   = 4,
    parameter int GPS   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             ovf,
    output logic             zero
);

    localparam int SW   = BLK * GPS;
    localparam int NSTG = cla_nstg(WIDTH, BLK, GPS);

    if ((WIDTH % SW) != 0 || NSTG < 1) begin : g_bad_cfg
        $error("cla_pipe_addsub: WIDTH must be a non-zero multiple of BLK*GPS");
    end

    logic                       adv;
    logic [NSTG-1:0]            valid_d, valid_q;
    logic [NSTG-1:0]            carry_d, carry_q;
    logic [NSTG-1:0][WIDTH-1:0] sum_d, sum_q;
    logic [NSTG-1:0][WIDTH-1:0] x_d, x_q;
    logic [NSTG-1:0][WIDTH-1:0] y_d, y_q;
    logic                       ovf_d, ovf_q;
    logic                       zero_d, zero_q;

    // Global stall: the whole pipe moves only when the output slot is free or draining.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [WIDTH-1:0]     xs, ys, sum_in, sum_nx;
        logic                 cin, vin;
        logic [GPS:0]         gc;
        logic [SW-1:0]        s_slice;
        grp_pg_t [GPS-1:0]    pg;

        if (k == 0) begin : g_src_in
            assign xs     = X;
            assign ys     = sub ? ~Y : Y;
            assign sum_in = '0;
            assign cin    = Ci;
            assign vin    = in_valid;
        end else begin : g_src_reg
            assign xs     = x_q[k-1];
            assign ys     = y_q[k-1];
            assign sum_in = sum_q[k-1];
            assign cin    = carry_q[k-1];
            assign vin    = valid_q[k-1];
        end

        assign gc[0] = cin;
        for (genvar gi = 0; gi < GPS; gi++) begin : g_grp
            cla_group #(.BLK(BLK)) u_grp (
                .x  (xs[k*SW + gi*BLK +: BLK]),
                .y  (ys[k*SW + gi*BLK +: BLK]),
                .ci (gc[gi]),
                .s  (s_slice[gi*BLK +: BLK]),
                .pg (pg[gi])
            );
            assign gc[gi+1] = pg[gi].g | (pg[gi].p & gc[gi]);
        end

        always_comb begin
            sum_nx               = sum_in;
            sum_nx[k*SW +: SW]   = s_slice;
        end

        assign valid_d[k] = vin;
        assign carry_d[k] = gc[GPS];
        assign sum_d[k]   = sum_nx;
        assign x_d[k]     = xs;
        assign y_d[k]     = ys;

        // Carry into the MSB is recovered as x^y^s at that bit, so no extra carry tap is needed.
        if (k == NSTG - 1) begin : g_flags
            assign ovf_d  = xs[WIDTH-1] ^ ys[WIDTH-1] ^ sum_nx[WIDTH-1] ^ gc[GPS];
            assign zero_d = ~|sum_nx;
        end
    end

    // The last stage has no consumer for its operand copies.
    logic unused_ops;
    assign unused_ops = ^{x_q[NSTG-1], y_q[NSTG-1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            sum_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (adv) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign out_valid = valid_q[NSTG-1];
    assign S         = sum_q[NSTG-1];
    assign Co        = carry_q[NSTG-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
